spio_spinn2aer_mapper: RTL and testbench



---
 rtl/spio_spinn2aer_mapper_pkg.sv | 30 +++
 rtl/spio_spinn2aer_mapper_decoder.sv | 23 ++
 rtl/spio_spinn2aer_mapper.sv | 116 +++++++++++
 tb/tb_spio_spinn2aer_mapper.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spio_spinn2aer_mapper_pkg.sv
// Shared constants for the SpiNNaker-to-AER output path: mode codes,
// packet field layout and the handshake state encoding.
package spio_spinn2aer_mapper_pkg;

   localparam int MODE_BITS = 3;
   localparam int VKEY_BITS = 16;
   localparam int PKT_BITS  = 72;

   // packet layout: [0] parity, [1] payload flag, [7:2] control,
   // [39:8] key, [71:40] payload
   localparam int PKT_PAR_BIT  = 0;
   localparam int PKT_KEY_LSB  = 8;
   localparam int PKT_HDR_MSB  = 39;
   localparam int PKT_PLD_LSB  = 40;

   localparam logic [MODE_BITS-1:0] RET_128 = 3'd0;
   localparam logic [MODE_BITS-1:0] RET_64  = 3'd1;
   localparam logic [MODE_BITS-1:0] RET_32  = 3'd2;
   localparam logic [MODE_BITS-1:0] RET_16  = 3'd3;
   localparam logic [MODE_BITS-1:0] COCHLEA = 3'd4;
   localparam logic [MODE_BITS-1:0] DIRECT  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_IDLE,
      ST_REQ,
      ST_ACK
   } state_e;

endpackage

// File: rtl/spio_spinn2aer_mapper_decoder.sv
// Combinational inverse coordinate map: 16-bit SpiNNaker key coordinate
// field to the AER address expected by the selected device type.
module spio_spinn2aer_decoder
   import spio_spinn2aer_mapper_pkg::*;
(
   input  logic [MODE_BITS-1:0] vmode,
   input  logic [15:0]          coord,
   output logic [15:0]          addr
);

   always_comb begin
      addr = {coord[15], coord[6:0], coord[13:7], coord[14]};
      case (vmode)
         RET_64:  addr = {coord[15], coord[5:0], 1'b0, coord[11:6], 1'b0, coord[14]};
         RET_32:  addr = {coord[15], coord[4:0], 2'b0, coord[9:5], 2'b0, coord[14]};
         RET_16:  addr = {coord[15], coord[3:0], 3'b0, coord[7:4], 3'b0, coord[14]};
         COCHLEA: addr = {coord[15], 5'b0, coord[1:0], coord[7:2], coord[11], 1'b0};
         DIRECT:  addr = coord;
         default: ;
      endcase
   end

endmodule

// File: rtl/spio_spinn2aer_mapper.sv
// Filters SpiNNaker multicast packets on the virtual key, maps the
// coordinate field to an AER address and drives a 4-phase active-low handshake.
module spio_spinn2aer_mapper
   import spio_spinn2aer_mapper_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_BITS    = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MODE_BITS-1:0] vmode,
   input  logic [VKEY_BITS-1:0] vkey,
   input  logic [PKT_BITS-1:0]  opkt_data,
   input  logic                 opkt_vld,
   output logic                 opkt_rdy,
   output logic [15:0]          oaer_data,
   output logic                 oaer_req,
   input  logic                 oaer_ack,
   output logic [CNT_BITS-1:0]  drop_cnt,
   output logic [CNT_BITS-1:0]  evt_cnt
);

   state_e                 state_q, state_d;
   logic                   rdy_q, rdy_d;
   logic                   req_q, req_d;
   logic [15:0]            data_q, data_d;
   logic [CNT_BITS-1:0]    drop_q, drop_d;
   logic [CNT_BITS-1:0]    evt_q, evt_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   logic        ack_s;
   logic [31:0] key;
   logic        par_ok;
   logic        key_ok;
   logic [15:0] map_addr;
   logic        payload_unused;

   assign ack_s          = sync_q[SYNC_STAGES-1];
   assign key            = opkt_data[PKT_KEY_LSB +: 32];
   assign par_ok         = ^opkt_data[PKT_HDR_MSB:PKT_PAR_BIT];
   assign key_ok         = (key[31:16] == vkey);
   assign payload_unused = ^opkt_data[PKT_BITS-1:PKT_PLD_LSB];

   spio_spinn2aer_decoder u_dec (
      .vmode (vmode),
      .coord (key[15:0]),
      .addr  (map_addr)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      drop_d  = drop_q;
      evt_d   = evt_q;
      sync_d  = {sync_q[SYNC_STAGES-2:0], oaer_ack};
      case (state_q)
         ST_IDLE: begin
            if (opkt_vld && rdy_q) begin
               if (par_ok && key_ok) begin
                  data_d  = map_addr;
                  state_d = ST_WAIT_IDLE;
               end else if (drop_q != '1) begin
                  drop_d = drop_q + CNT_BITS'(1);
               end
            end
         end
         // hold off the request until the device has released any stale ack
         ST_WAIT_IDLE: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!ack_s) begin
               req_d   = 1'b1;
               evt_d   = evt_q + CNT_BITS'(1);
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (ack_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      rdy_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rdy_q   <= 1'b0;
         req_q   <= 1'b1;
         data_q  <= 16'h0000;
         drop_q  <= '0;
         evt_q   <= '0;
         sync_q  <= '1;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         req_q   <= req_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
         evt_q   <= evt_d;
         sync_q  <= sync_d;
      end
   end

   assign opkt_rdy  = rdy_q;
   assign oaer_req  = req_q;
   assign oaer_data = data_q;
   assign drop_cnt  = drop_q;
   assign evt_cnt   = evt_q;

endmodule

// File: tb/tb_spio_spinn2aer_mapper.sv
// Directed bench for the SpiNNaker-to-AER mapper; the bench plays the AER
// device by driving oaer_ack by hand.
module tb_spio_spinn2aer_mapper;
   import spio_spinn2aer_mapper_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [MODE_BITS-1:0] vmode;
   logic [VKEY_BITS-1:0] vkey;
   logic [PKT_BITS-1:0]  opkt_data;
   logic                 opkt_vld;
   logic                 opkt_rdy;
   logic [15:0]          oaer_data;
   logic                 oaer_req;
   logic                 oaer_ack;
   logic [15:0]          drop_cnt;
   logic [15:0]          evt_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spio_spinn2aer_mapper #(.SYNC_STAGES(2), .CNT_BITS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .vmode     (vmode),
      .vkey      (vkey),
      .opkt_data (opkt_data),
      .opkt_vld  (opkt_vld),
      .opkt_rdy  (opkt_rdy),
      .oaer_data (oaer_data),
      .oaer_req  (oaer_req),
      .oaer_ack  (oaer_ack),
      .drop_cnt  (drop_cnt),
      .evt_cnt   (evt_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // key in [39:8], payload junk in [71:40], parity bit chosen for odd header parity
   function automatic logic [PKT_BITS-1:0] mk_pkt(input logic [31:0] k);
      logic [PKT_BITS-1:0] p;
      p = {32'hDEAD_BEEF, k, 8'h00};
      p[0] = ~^p[39:0];
      return p;
   endfunction

   task automatic wait_req(input logic lvl, input string tag);
      int n = 0;
      while (oaer_req !== lvl && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'b0, oaer_req}, {31'b0, lvl});
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (opkt_rdy !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'b0, opkt_rdy}, 32'd1);
   endtask

   // single-cycle valid pulse, entered and left on a negedge
   task automatic send(input logic [PKT_BITS-1:0] p);
      wait_rdy("send_rdy");
      opkt_data = p;
      opkt_vld  = 1'b1;
      @(negedge clk);
      opkt_vld  = 1'b0;
   endtask

   task automatic handshake(input string tag);
      wait_req(1'b0, {tag, "_req_lo"});
      oaer_ack = 1'b0;
      wait_req(1'b1, {tag, "_req_hi"});
      oaer_ack = 1'b1;
      wait_rdy({tag, "_rdy"});
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      vmode     = RET_128;
      vkey      = 16'h0200;
      opkt_data = '0;
      opkt_vld  = 1'b0;
      oaer_ack  = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_rdy",  {31'b0, opkt_rdy}, 32'd0);
      chk("rst_req",  {31'b0, oaer_req}, 32'd1);
      chk("rst_data", {16'b0, oaer_data}, 32'h0000);
      chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
      chk("rst_evt",  {16'b0, evt_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rdy", {31'b0, opkt_rdy}, 32'd1);

      // RET_128 event, device acks 3 cycles after req falls
      send(mk_pkt(32'h0200_4505));
      chk("r128_data", {16'b0, oaer_data}, 32'h0515);
      chk("r128_rdy_lo", {31'b0, opkt_rdy}, 32'd0);
      chk("r128_req_still_hi", {31'b0, oaer_req}, 32'd1);
      wait_req(1'b0, "r128_req_lo");
      repeat (3) @(negedge clk);
      oaer_ack = 1'b0;
      wait_req(1'b1, "r128_req_hi");
      chk("r128_evt", {16'b0, evt_cnt}, 32'd1);
      chk("r128_rdy_during_ack", {31'b0, opkt_rdy}, 32'd0);
      oaer_ack = 1'b1;
      wait_rdy("r128_rdy_back");

      // parity error
      send(mk_pkt(32'h0200_4505) ^ 72'h1);
      chk("par_drop", {16'b0, drop_cnt}, 32'd1);
      chk("par_rdy", {31'b0, opkt_rdy}, 32'd1);
      // ack glitch while idle must not start anything
      oaer_ack = 1'b0;
      @(negedge clk);
      oaer_ack = 1'b1;
      repeat (4) @(negedge clk);
      chk("par_glitch_req", {31'b0, oaer_req}, 32'd1);
      chk("par_glitch_rdy", {31'b0, opkt_rdy}, 32'd1);
      chk("par_glitch_evt", {16'b0, evt_cnt}, 32'd1);

      // key mismatch, two back-to-back packets one cycle each
      opkt_data = mk_pkt(32'h0300_4505);
      opkt_vld  = 1'b1;
      @(negedge clk);
      chk("key_drop1", {16'b0, drop_cnt}, 32'd2);
      chk("key_rdy1", {31'b0, opkt_rdy}, 32'd1);
      @(negedge clk);
      opkt_vld = 1'b0;
      chk("key_drop2", {16'b0, drop_cnt}, 32'd3);
      chk("key_req", {31'b0, oaer_req}, 32'd1);

      // DIRECT; mode change mid-handshake must not disturb the event
      vmode = DIRECT;
      send(mk_pkt(32'h0200_A5C3));
      vmode = RET_128;
      chk("direct_data", {16'b0, oaer_data}, 32'hA5C3);
      handshake("direct");
      chk("direct_data_hold", {16'b0, oaer_data}, 32'hA5C3);
      chk("direct_evt", {16'b0, evt_cnt}, 32'd2);

      vmode = COCHLEA;
      send(mk_pkt(32'h0200_08FF));
      chk("coch_data", {16'b0, oaer_data}, 32'h03FE);
      handshake("coch");
      chk("coch_evt", {16'b0, evt_cnt}, 32'd3);

      // RET_64 with the device holding ack low for 20 cycles
      vmode = RET_64;
      send(mk_pkt(32'h0200_4505));
      chk("r64_data", {16'b0, oaer_data}, 32'h0A51);
      wait_req(1'b0, "hold_req_lo");
      oaer_ack = 1'b0;
      wait_req(1'b1, "hold_req_hi");
      opkt_data = mk_pkt(32'h0200_8001);
      opkt_vld  = 1'b1;
      repeat (20) @(negedge clk);
      chk("hold_rdy", {31'b0, opkt_rdy}, 32'd0);
      chk("hold_data", {16'b0, oaer_data}, 32'h0A51);
      chk("hold_evt", {16'b0, evt_cnt}, 32'd4);
      oaer_ack = 1'b1;
      wait_rdy("hold_rdy_back");
      @(negedge clk);
      opkt_vld = 1'b0;
      chk("hold_second_data", {16'b0, oaer_data}, 32'h8200);
      handshake("second");
      chk("second_evt", {16'b0, evt_cnt}, 32'd5);

      // reset while in REQ
      vmode = RET_128;
      send(mk_pkt(32'h0200_4505));
      wait_req(1'b0, "rreq_req_lo");
      rst = 1'b1;
      @(negedge clk);
      chk("rreq_req", {31'b0, oaer_req}, 32'd1);
      chk("rreq_rdy", {31'b0, opkt_rdy}, 32'd0);
      chk("rreq_drop", {16'b0, drop_cnt}, 32'd0);
      chk("rreq_evt", {16'b0, evt_cnt}, 32'd0);
      chk("rreq_data", {16'b0, oaer_data}, 32'h0000);
      rst = 1'b0;
      send(mk_pkt(32'h0200_4505));
      chk("after_rst_data", {16'b0, oaer_data}, 32'h0515);
      handshake("after_rst");
      chk("after_rst_evt", {16'b0, evt_cnt}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
